// File: rtl/pcie_pkg.sv
// Shared definitions for the PCIE receive path: K28.5 comma codes,
// aligner lock states and symbol width.
package pcie_pkg;

   localparam int SYM_W = 10;

   localparam logic [SYM_W-1:0] K285_RDN = 10'b0011111010;
   localparam logic [SYM_W-1:0] K285_RDP = 10'b1100000101;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      SYNC   = 2'd1,
      LOCKED = 2'd2
   } estado_t;

   function automatic logic es_coma(input logic [SYM_W-1:0] cand);
      return (cand == K285_RDN) || (cand == K285_RDP);
   endfunction

endpackage

// File: rtl/empaquetador_simbolos.sv
// Packs aligned symbols into a word, earliest symbol in the low slot.
// 'clear' drops any partial word and restarts at slot 0 on the same cycle.
module empaquetador_simbolos
   import pcie_pkg::*;
#(
   parameter int SYM_POR_PALABRA = 2
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               enb,
   input  logic [SYM_W-1:0]                   symIn,
   input  logic                               symValid,
   input  logic                               clear,
   output logic [SYM_W*SYM_POR_PALABRA-1:0]   wordOut,
   output logic                               wordValid
);

   localparam int SLOT_W = (SYM_POR_PALABRA > 1) ? $clog2(SYM_POR_PALABRA) : 1;
   localparam logic [SLOT_W-1:0] ULTIMO = SLOT_W'(SYM_POR_PALABRA - 1);

   logic [SLOT_W-1:0]                 r_slot;
   logic [SLOT_W-1:0]                 w_slot;
   logic [SYM_W*SYM_POR_PALABRA-1:0]  r_buf;
   logic [SYM_W*SYM_POR_PALABRA-1:0]  w_palabra;

   // A clear coinciding with a symbol places that symbol in slot 0.
   always_comb begin
      w_slot    = clear ? '0 : r_slot;
      w_palabra = r_buf;
      w_palabra[SYM_W*w_slot +: SYM_W] = symIn;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_slot    <= '0;
         r_buf     <= '0;
         wordOut   <= '0;
         wordValid <= 1'b0;
      end else if (!enb) begin
         wordValid <= 1'b0;
      end else begin
         wordValid <= 1'b0;
         if (symValid) begin
            r_buf <= w_palabra;
            if (w_slot == ULTIMO) begin
               wordOut   <= w_palabra;
               wordValid <= 1'b1;
               r_slot    <= '0;
            end else begin
               r_slot <= w_slot + 1'b1;
            end
         end else if (clear) begin
            r_slot <= '0;
         end
      end
   end

endmodule

// File: rtl/alineador_k285.sv
// Comma-aligning deserialiser: finds K28.5, runs the lock FSM and emits
// aligned symbols plus packed words once locked.
//
//   state  | meaning
//   HUNT   | no symbol phase; first comma of either kind sets the boundary
//   SYNC   | phase chosen; counting consecutive aligned commas towards lock
//   LOCKED | emitting symbols; counting misaligned commas towards loss
module alineador_k285
   import pcie_pkg::*;
#(
   parameter int LOCK_COMMAS     = 3,
   parameter int LOSS_ERRORS     = 4,
   parameter int SYM_POR_PALABRA = 2
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               enb,
   input  logic                               serialIn,
   output logic [SYM_W-1:0]                   symOut,
   output logic                               symValid,
   output logic [SYM_W*SYM_POR_PALABRA-1:0]   wordOut,
   output logic                               wordValid,
   output logic                               esk285,
   output logic                               lock
);

   estado_t      r_estado;
   logic [8:0]   r_sr;
   logic [3:0]   r_cnt;
   logic [3:0]   r_coma_cnt;
   logic [3:0]   r_err_cnt;

   logic [SYM_W-1:0] w_cand;
   logic             w_coma;
   logic             w_frontera;
   logic             w_bloquea;
   logic             w_pierde;
   logic             w_emite;

   assign w_cand     = {r_sr, serialIn};
   assign w_coma     = es_coma(w_cand);
   assign w_frontera = (r_cnt == 4'd9);
   assign w_bloquea  = (r_estado == SYNC) && w_coma && w_frontera &&
                       ((r_coma_cnt + 4'd1) == 4'(LOCK_COMMAS));
   assign w_pierde   = (r_estado == LOCKED) && w_coma && !w_frontera &&
                       ((r_err_cnt + 4'd1) == 4'(LOSS_ERRORS));
   // The locking boundary itself is the first emitted symbol.
   assign w_emite    = w_bloquea || ((r_estado == LOCKED) && w_frontera);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_estado   <= HUNT;
         r_sr       <= '0;
         r_cnt      <= '0;
         r_coma_cnt <= '0;
         r_err_cnt  <= '0;
         symOut     <= '0;
         symValid   <= 1'b0;
         esk285     <= 1'b0;
         lock       <= 1'b0;
      end else if (!enb) begin
         symValid <= 1'b0;
         esk285   <= 1'b0;
      end else begin
         r_sr     <= w_cand[8:0];
         r_cnt    <= w_frontera ? 4'd0 : r_cnt + 4'd1;
         symValid <= w_emite;
         esk285   <= w_emite && w_coma;
         if (w_emite) symOut <= w_cand;

         case (r_estado)
            HUNT: begin
               if (w_coma) begin
                  r_cnt      <= 4'd0;
                  r_coma_cnt <= 4'd1;
                  r_estado   <= SYNC;
               end
            end
            SYNC: begin
               if (w_coma) begin
                  if (w_frontera) begin
                     r_coma_cnt <= r_coma_cnt + 4'd1;
                     if (w_bloquea) begin
                        r_estado  <= LOCKED;
                        r_err_cnt <= 4'd0;
                        lock      <= 1'b1;
                     end
                  end else begin
                     r_cnt      <= 4'd0;
                     r_coma_cnt <= 4'd1;
                  end
               end
            end
            LOCKED: begin
               if (w_coma) begin
                  if (w_frontera) begin
                     r_err_cnt <= 4'd0;
                  end else if (w_pierde) begin
                     r_estado   <= HUNT;
                     r_err_cnt  <= 4'd0;
                     r_coma_cnt <= 4'd0;
                     lock       <= 1'b0;
                  end else begin
                     r_err_cnt <= r_err_cnt + 4'd1;
                  end
               end
            end
            default: r_estado <= HUNT;
         endcase
      end
   end

   empaquetador_simbolos #(
      .SYM_POR_PALABRA (SYM_POR_PALABRA)
   ) u_empaquetador (
      .clk       (clk),
      .rst       (rst),
      .enb       (enb),
      .symIn     (w_cand),
      .symValid  (w_emite),
      .clear     (w_bloquea || w_pierde),
      .wordOut   (wordOut),
      .wordValid (wordValid)
   );

endmodule

// File: tb/tb_alineador_k285.sv
// Directed bench for alineador_k285: reset, lock, re-phase, loss,
// packing, enable stalls and asynchronous reset mid-word.
module tb_alineador_k285;

   localparam logic [9:0] KN   = 10'h0FA;
   localparam logic [9:0] KP   = 10'h305;
   localparam logic [9:0] D215 = 10'h2AA;

   logic        clk;
   logic        rst;
   logic        enb;
   logic        serialIn;
   logic [9:0]  symOut;
   logic        symValid;
   logic [19:0] wordOut;
   logic        wordValid;
   logic        esk285;
   logic        lock;

   int n_tests = 0;
   int n_fail  = 0;

   logic [9:0]  sym_log  [0:255];
   logic        esk_log  [0:255];
   logic [19:0] word_log [0:255];
   logic        word_sv  [0:255];
   int          n_sym = 0;
   int          n_word = 0;
   int          esk_orphan = 0;
   logic        lock_q = 1'b0;
   logic        lock_rise_sv = 1'b0;
   logic [9:0]  lock_rise_sym = '0;

   int bs;
   int bw;

   alineador_k285 #(
      .LOCK_COMMAS     (3),
      .LOSS_ERRORS     (4),
      .SYM_POR_PALABRA (2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .enb       (enb),
      .serialIn  (serialIn),
      .symOut    (symOut),
      .symValid  (symValid),
      .wordOut   (wordOut),
      .wordValid (wordValid),
      .esk285    (esk285),
      .lock      (lock)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (symValid) begin
         if (n_sym < 256) begin
            sym_log[n_sym] = symOut;
            esk_log[n_sym] = esk285;
         end
         n_sym++;
      end else if (esk285) begin
         esk_orphan++;
      end
      if (wordValid) begin
         if (n_word < 256) begin
            word_log[n_word] = wordOut;
            word_sv[n_word]  = symValid;
         end
         n_word++;
      end
      if (lock && !lock_q) begin
         lock_rise_sv  = symValid;
         lock_rise_sym = symOut;
      end
      lock_q = lock;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      @(negedge clk);
      enb      = 1'b1;
      serialIn = b;
      @(posedge clk);
      #1;
   endtask

   task automatic send_bits(input logic [9:0] s, input int hi, input int lo);
      for (int i = hi; i >= lo; i--) send_bit(s[i]);
   endtask

   task automatic send_sym(input logic [9:0] s);
      send_bits(s, 9, 0);
   endtask

   task automatic send_zeros(input int n);
      for (int i = 0; i < n; i++) send_bit(1'b0);
   endtask

   task automatic stall(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         enb      = 1'b0;
         serialIn = ~serialIn;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst      = 1'b0;
      serialIn = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      rst      = 1'b0;
      enb      = 1'b1;
      serialIn = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_outputs", {symOut, wordOut, symValid, wordValid, esk285, lock}, 64'd0);
      rst = 1'b1;

      // idle zeros after release
      send_zeros(40);
      check("idle_outputs", {symOut, wordOut, symValid, wordValid, esk285, lock}, 64'd0);
      check("idle_no_syms", 64'(n_sym), 64'd0);
      check("idle_no_words", 64'(n_word), 64'd0);

      // three commas after junk bits
      do_reset();
      bs = n_sym;
      bw = n_word;
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
      send_sym(KN);
      check("t2_lock_after_1", 64'(lock), 64'd0);
      send_sym(KP);
      check("t2_lock_after_2", 64'(lock), 64'd0);
      send_sym(KN);
      check("t2_lock_after_3", 64'(lock), 64'd1);
      check("t2_lock_sym", {symValid, esk285, symOut}, {1'b1, 1'b1, KN});
      send_sym(KP);
      send_zeros(2);
      check("t2_nsym", 64'(n_sym - bs), 64'd2);
      check("t2_sym0", {esk_log[bs], sym_log[bs]}, {1'b1, KN});
      check("t2_sym1", {esk_log[bs+1], sym_log[bs+1]}, {1'b1, KP});
      check("t2_lock_rise_sv", {lock_rise_sv, lock_rise_sym}, {1'b1, KN});
      check("t2_nword", 64'(n_word - bw), 64'd1);
      check("t2_word0", {word_sv[bw], word_log[bw]}, {1'b1, 20'hC14FA});

      // re-phase in SYNC
      do_reset();
      send_sym(KN);
      send_sym(KP);
      send_zeros(4);
      send_sym(KN);
      check("t3_lock_after_shift", 64'(lock), 64'd0);
      send_sym(KP);
      check("t3_lock_after_1new", 64'(lock), 64'd0);
      send_sym(KN);
      check("t3_lock_after_2new", {lock, symValid, symOut}, {1'b1, 1'b1, KN});
      send_sym(KP);
      check("t3_lock_held", {lock, symValid, symOut}, {1'b1, 1'b1, KP});

      // loss of lock after four misaligned commas
      do_reset();
      send_sym(KN); send_sym(KP); send_sym(KN);
      check("t4_locked", 64'(lock), 64'd1);
      send_bit(1'b0); send_sym(KP);
      send_bit(1'b0); send_sym(KN);
      send_bit(1'b0); send_sym(KP);
      check("t4_lock_after_3err", 64'(lock), 64'd1);
      send_bit(1'b0); send_sym(KN);
      check("t4_lock_after_4err", {lock, symValid}, {1'b0, 1'b0});

      // aligned comma resets the error count
      do_reset();
      send_sym(KN); send_sym(KP); send_sym(KN);
      send_bit(1'b0); send_sym(KP);
      send_bit(1'b0); send_sym(KN);
      send_zeros(8);
      send_sym(KP);
      check("t4b_aligned", {symValid, esk285, symOut}, {1'b1, 1'b1, KP});
      send_bit(1'b0); send_sym(KN);
      send_bit(1'b0); send_sym(KP);
      send_bit(1'b0); send_sym(KN);
      check("t4b_no_loss", 64'(lock), 64'd1);

      // packing: lock then D21.5
      do_reset();
      bs = n_sym;
      bw = n_word;
      send_sym(KN); send_sym(KP); send_sym(KN);
      send_sym(D215);
      check("t5_word", {wordValid, symValid, esk285, symOut, wordOut},
            {1'b1, 1'b1, 1'b0, D215, 20'hAA8FA});
      stall(2);
      check("t5_stall_strobes", {wordValid, symValid, esk285, symOut, wordOut, lock},
            {1'b0, 1'b0, 1'b0, D215, 20'hAA8FA, 1'b1});

      // enable low mid-symbol
      send_bits(KP, 9, 5);
      stall(7);
      check("t6_stall_hold", {wordValid, symValid, esk285, symOut, wordOut, lock},
            {1'b0, 1'b0, 1'b0, D215, 20'hAA8FA, 1'b1});
      send_bits(KP, 4, 0);
      check("t6_resume_sym", {symValid, esk285, symOut}, {1'b1, 1'b1, KP});
      send_sym(D215);
      check("t6_resume_word", {wordValid, wordOut}, {1'b1, 20'hAAB05});
      send_sym(KN);
      check("t6_partial_sym", {symValid, wordValid, symOut}, {1'b1, 1'b0, KN});
      send_zeros(4);

      // asynchronous reset mid-word
      @(negedge clk);
      #2 rst = 1'b0;
      #1 check("t6_rst_async", {lock, symOut, wordOut, symValid, wordValid}, 64'd0);
      #1 rst = 1'b1;
      send_sym(D215);
      send_sym(KP);
      send_sym(KN);
      check("t6_relock_pending", 64'(lock), 64'd0);
      send_sym(KP);
      check("t6_relock", {lock, symValid, symOut}, {1'b1, 1'b1, KP});
      send_zeros(2);
      check("t6_nsym", 64'(n_sym - bs), 64'd6);
      check("t6_nword", 64'(n_word - bw), 64'd2);
      check("t6_word0_sv", 64'(word_sv[bw]), 64'd1);
      check("t6_word1", {word_sv[bw+1], word_log[bw+1]}, {1'b1, 20'hAAB05});
      check("t6_sym3", {esk_log[bs+3], sym_log[bs+3]}, {1'b0, D215});
      check("t6_sym4", {esk_log[bs+4], sym_log[bs+4]}, {1'b1, KN});
      check("t6_sym5", {esk_log[bs+5], sym_log[bs+5]}, {1'b1, KP});
      check("esk_without_sym", 64'(esk_orphan), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
